// File: rtl/pcw_dn_pkg.sv
// Shared types and defaults for the boot-loader download receiver.
package pcw_dn_pkg;

  localparam int unsigned DN_DEPTH_DEFAULT = 4;
  localparam int unsigned DN_ADDR_W        = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StDone
  } dn_state_t;

  // Layout of one captured byte at the default address width.
  typedef struct packed {
    logic [DN_ADDR_W-1:0] addr;
    logic [7:0]           data;
  } dn_entry_t;

endpackage

// File: rtl/boot_dn_receiver_if.sv
// Download strobe bus, RAM write port and session status of the receiver.
interface boot_dn_receiver_if #(
  parameter int unsigned ADDR_W = 16
);

  logic              dn_go;
  logic              dn_wr;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wait;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_gnt;

  logic              cpu_hold;
  logic              load_done;
  logic              overflow;
  logic [ADDR_W:0]   byte_count;

  // Loader / RAM arbiter side.
  modport master (
    output dn_go, dn_wr, dn_addr, dn_data, mem_gnt,
    input  dn_wait, mem_req, mem_addr, mem_din, cpu_hold, load_done, overflow, byte_count
  );

  // Receiver side.
  modport slave (
    input  dn_go, dn_wr, dn_addr, dn_data, mem_gnt,
    output dn_wait, mem_req, mem_addr, mem_din, cpu_hold, load_done, overflow, byte_count
  );

endinterface

// File: rtl/dn_fifo.sv
// Register-based synchronous FIFO; a push while full is accepted only alongside a pop.
module dn_fifo
  import pcw_dn_pkg::*;
#(
  parameter int unsigned Depth = DN_DEPTH_DEFAULT,
  parameter type entry_t = dn_entry_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  entry_t                 wdata_i,
  output entry_t                 rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AW = $clog2(Depth);

  entry_t        mem_q [Depth];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // When full, the slot being written is the one popped this cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/boot_dn_receiver.sv
// Captures loader bytes into a FIFO and writes them to RAM, holding the CPU for the session.
module boot_dn_receiver
  import pcw_dn_pkg::*;
#(
  parameter int unsigned DEPTH  = DN_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = DN_ADDR_W
) (
  input logic               clk_sys,
  input logic               reset,
  boot_dn_receiver_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } entry_t;

  localparam logic [ADDR_W:0] CountMax = '1;

  dn_state_t       state_q, state_d;
  logic            dn_wr_q, dn_go_q;
  logic            dn_wait_q, dn_wait_d;
  logic            overflow_q, overflow_d;
  logic [ADDR_W:0] byte_count_q, byte_count_d;
  logic            strobe, go_rise, pop, push_ok, drop, start;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count, fifo_count_next;
  entry_t          wr_entry, head;

  assign strobe          = bus.dn_go & bus.dn_wr & ~dn_wr_q;
  assign go_rise         = bus.dn_go & ~dn_go_q;
  assign pop             = ~fifo_empty & bus.mem_gnt;
  assign push_ok         = strobe & (~fifo_full | pop);
  assign drop            = strobe & fifo_full & ~pop;
  assign wr_entry        = '{addr: bus.dn_addr, data: bus.dn_data};
  assign fifo_count_next = fifo_count + CW'(push_ok) - CW'(pop);
  assign dn_wait_d       = (fifo_count_next >= CW'(DEPTH - 1));

  dn_fifo #(
    .Depth   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .push_i  (strobe),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Session state machine; a re-raised dn_go while draining continues the session.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go_rise) begin
          state_d = StLoad;
          start   = 1'b1;
        end
      end
      StLoad: begin
        if (!bus.dn_go) state_d = StDrain;
      end
      StDrain: begin
        if (go_rise) begin
          state_d = StLoad;
        end else if (fifo_empty) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Committed-byte counter (saturating) and sticky drop flag, both cleared at session start.
  always_comb begin
    byte_count_d = start ? '0 : byte_count_q;
    if (pop && (byte_count_d != CountMax)) byte_count_d = byte_count_d + 1'b1;
    overflow_d = (start ? 1'b0 : overflow_q) | drop;
  end

  // State, edge-detect and status registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      dn_wr_q      <= 1'b0;
      dn_go_q      <= 1'b0;
      dn_wait_q    <= 1'b0;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      dn_wr_q      <= bus.dn_wr;
      dn_go_q      <= bus.dn_go;
      dn_wait_q    <= dn_wait_d;
      overflow_q   <= overflow_d;
      byte_count_q <= byte_count_d;
    end
  end

  // Head is masked while empty so the port reads zero out of reset.
  assign bus.mem_req    = ~fifo_empty;
  assign bus.mem_addr   = fifo_empty ? '0 : head.addr;
  assign bus.mem_din    = fifo_empty ? '0 : head.data;
  assign bus.dn_wait    = dn_wait_q;
  assign bus.cpu_hold   = (state_q != StIdle) | ~fifo_empty;
  assign bus.load_done  = (state_q == StDone);
  assign bus.overflow   = overflow_q;
  assign bus.byte_count = byte_count_q;

endmodule

// File: tb/tb_boot_dn_receiver.sv
// Self-checking bench for boot_dn_receiver with a commit scoreboard and RAM model.
module tb_boot_dn_receiver;

  logic clk;
  logic reset;

  boot_dn_receiver_if #(.ADDR_W(16)) bus ();

  boot_dn_receiver #(
    .DEPTH  (4),
    .ADDR_W (16)
  ) dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [23:0] sb [$];
  logic [23:0] mon_exp;
  int          cap_n    = 0;
  int          com_n    = 0;
  int          done_cnt = 0;
  int          gnt_mode = 0;
  int          gcyc     = 0;
  logic [7:0]  ram [0:65535];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM arbiter: 0 = always grant, 1 = every 8th cycle, other = never.
  initial begin
    bus.mem_gnt = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      gcyc++;
      case (gnt_mode)
        0:       bus.mem_gnt = 1'b1;
        1:       bus.mem_gnt = ((gcyc % 8) == 0);
        default: bus.mem_gnt = 1'b0;
      endcase
    end
  end

  // Commit monitor: a granted request at this negedge commits at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.load_done) done_cnt++;
      if (!reset && bus.mem_req && bus.mem_gnt) begin
        com_n++;
        ram[bus.mem_addr] = bus.mem_din;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL commit_unexpected: got addr=%h data=%h, required no commit",
                   bus.mem_addr, bus.mem_din);
        end else begin
          mon_exp = sb.pop_front();
          if ({bus.mem_addr, bus.mem_din} !== mon_exp) begin
            bad++;
            $display("FAIL commit_order: got addr=%h data=%h, required addr=%h data=%h",
                     bus.mem_addr, bus.mem_din, mon_exp[23:8], mon_exp[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [7:0] img(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One byte strobe over two cycles, optionally waiting out dn_wait first.
  task automatic strobe(input logic [15:0] a, input logic [7:0] d, input bit exp_cap,
                        input bit gate);
    int n;
    n = 0;
    while (gate && bus.dn_wait && n < 300) begin
      step(1);
      n++;
    end
    if (gate && bus.dn_wait) begin
      total++;
      bad++;
      $display("FAIL strobe_gate: dn_wait=1 after %0d cycles, required 0", n);
    end
    bus.dn_addr = a;
    bus.dn_data = d;
    bus.dn_wr   = 1'b1;
    step(1);
    if (exp_cap) begin
      sb.push_back({a, d});
      cap_n++;
    end
    bus.dn_wr = 1'b0;
    step(1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!bus.load_done && n < budget) begin
      step(1);
      n++;
    end
    total++;
    if (!bus.load_done) begin
      bad++;
      $display("FAIL wait_done: load_done=0 after %0d cycles, required 1", budget);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.dn_go   = 1'b0;
    bus.dn_wr   = 1'b0;
    bus.dn_addr = '0;
    bus.dn_data = '0;
    step(3);
    total++;
    if ({bus.mem_req, bus.cpu_hold, bus.load_done, bus.overflow, bus.dn_wait} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: req/hold/done/ovf/wait=%b, required 00000",
               {bus.mem_req, bus.cpu_hold, bus.load_done, bus.overflow, bus.dn_wait});
    end
    total++;
    if ({bus.mem_addr, bus.mem_din, bus.byte_count} !== '0) begin
      bad++;
      $display("FAIL reset_values: addr=%h din=%h count=%0d, required 0 0 0",
               bus.mem_addr, bus.mem_din, bus.byte_count);
    end
    reset = 1'b0;
    step(2);
    total++;
    if (bus.cpu_hold !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_hold: cpu_hold=%b, required 0", bus.cpu_hold);
    end
  endtask

  task automatic test_single_session();
    int d0;
    gnt_mode = 0;
    d0 = done_cnt;
    bus.dn_go = 1'b1;
    step(1);
    for (int i = 0; i < 276; i++) strobe(16'(i), img(i), 1'b1, 1'b0);
    bus.dn_go = 1'b0;
    wait_done(50);
    total++;
    if (bus.byte_count !== 17'd276) begin
      bad++;
      $display("FAIL single_count: byte_count=%0d, required 276", bus.byte_count);
    end
    step(1);
    total++;
    if ({bus.load_done, bus.cpu_hold} !== 2'b00) begin
      bad++;
      $display("FAIL single_after_done: done/hold=%b, required 00",
               {bus.load_done, bus.cpu_hold});
    end
    step(3);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL single_done_pulses: pulses=%0d, required 1", done_cnt - d0);
    end
    total++;
    if (bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL single_overflow: overflow=%b, required 0", bus.overflow);
    end
    for (int i = 0; i < 276; i++) begin
      total++;
      if (ram[i] !== img(i)) begin
        bad++;
        $display("FAIL single_ram: ram[%0d]=%h, required %h", i, ram[i], img(i));
      end
    end
  endtask

  task automatic test_back_pressure();
    int  sent;
    bit  drove;
    bit  seen;
    bit  exp_wait;
    gnt_mode = 1;
    sent = 0;
    seen = 1'b0;
    bus.dn_go = 1'b1;
    step(1);
    for (int c = 0; c < 3000 && sent < 24; c++) begin
      drove = 1'b0;
      if (bus.dn_wr) begin
        bus.dn_wr = 1'b0;
      end else if (!bus.dn_wait) begin
        bus.dn_addr = 16'h4000 + 16'(sent);
        bus.dn_data = img(sent + 100);
        bus.dn_wr   = 1'b1;
        drove       = 1'b1;
      end
      step(1);
      if (drove) begin
        sb.push_back({bus.dn_addr, bus.dn_data});
        cap_n++;
        sent++;
      end
      exp_wait = ((cap_n - com_n) >= 3);
      total++;
      if (bus.dn_wait !== exp_wait) begin
        bad++;
        $display("FAIL bp_wait: dn_wait=%b at occupancy %0d, required %b",
                 bus.dn_wait, cap_n - com_n, exp_wait);
      end
      if (!seen && bus.dn_wait) begin
        seen = 1'b1;
        total++;
        if (cap_n - com_n != 3) begin
          bad++;
          $display("FAIL bp_first_wait: occupancy=%0d at first dn_wait, required 3",
                   cap_n - com_n);
        end
      end
    end
    bus.dn_wr = 1'b0;
    bus.dn_go = 1'b0;
    wait_done(400);
    total++;
    if ({seen, bus.overflow, bus.byte_count} !== {1'b1, 1'b0, 17'd24}) begin
      bad++;
      $display("FAIL bp_final: seen_wait=%b overflow=%b count=%0d, required 1 0 24",
               seen, bus.overflow, bus.byte_count);
    end
    step(2);
  endtask

  task automatic test_overflow();
    int d0;
    gnt_mode = 2;
    step(2);
    d0 = done_cnt;
    bus.dn_go = 1'b1;
    step(1);
    bus.dn_addr = 16'h1000;
    bus.dn_data = 8'hA0;
    bus.dn_wr   = 1'b1;
    step(1);
    sb.push_back({16'h1000, 8'hA0});
    cap_n++;
    total++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_din} !== {1'b1, 16'h1000, 8'hA0}) begin
      bad++;
      $display("FAIL ovf_latency: req=%b addr=%h din=%h, required 1 1000 a0",
               bus.mem_req, bus.mem_addr, bus.mem_din);
    end
    bus.dn_wr = 1'b0;
    step(1);
    for (int i = 1; i < 5; i++) strobe(16'h1000 + 16'(i), 8'hA0 + 8'(i), (i < 4), 1'b0);
    total++;
    if ({bus.overflow, bus.dn_wait, bus.mem_din} !== {1'b1, 1'b1, 8'hA0}) begin
      bad++;
      $display("FAIL ovf_full: overflow=%b wait=%b head=%h, required 1 1 a0",
               bus.overflow, bus.dn_wait, bus.mem_din);
    end
    gnt_mode = 0;
    bus.dn_go = 1'b0;
    wait_done(50);
    total++;
    if ({bus.byte_count, bus.overflow} !== {17'd4, 1'b1}) begin
      bad++;
      $display("FAIL ovf_commit: count=%0d overflow=%b, required 4 1",
               bus.byte_count, bus.overflow);
    end
    step(2);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL ovf_done: pulses=%0d, required 1", done_cnt - d0);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ram[16'h1000 + i] !== 8'hA0 + 8'(i)) begin
        bad++;
        $display("FAIL ovf_ram: ram[%h]=%h, required %h", 16'h1000 + i,
                 ram[16'h1000 + i], 8'hA0 + 8'(i));
      end
    end
  endtask

  task automatic test_held_strobe();
    int d0;
    gnt_mode = 0;
    bus.dn_addr = 16'h2000;
    bus.dn_data = 8'h55;
    bus.dn_wr   = 1'b1;
    step(2);
    total++;
    if ({bus.mem_req, bus.cpu_hold} !== 2'b00) begin
      bad++;
      $display("FAIL held_no_go: req/hold=%b, required 00", {bus.mem_req, bus.cpu_hold});
    end
    bus.dn_wr = 1'b0;
    step(1);
    d0 = done_cnt;
    bus.dn_go = 1'b1;
    step(1);
    bus.dn_addr = 16'h2001;
    bus.dn_data = 8'h66;
    bus.dn_wr   = 1'b1;
    step(1);
    sb.push_back({16'h2001, 8'h66});
    cap_n++;
    step(4);
    bus.dn_wr = 1'b0;
    step(1);
    bus.dn_go = 1'b0;
    wait_done(50);
    total++;
    if (bus.byte_count !== 17'd1) begin
      bad++;
      $display("FAIL held_count: byte_count=%0d, required 1", bus.byte_count);
    end
    step(2);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL held_done: pulses=%0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_continuation();
    int d0;
    gnt_mode = 1;
    d0 = done_cnt;
    bus.dn_go = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) strobe(16'h3000 + 16'(i), 8'h30 + 8'(i), 1'b1, 1'b1);
    bus.dn_go = 1'b0;
    step(1);
    total++;
    if ({bus.cpu_hold, bus.mem_req, bus.load_done} !== 3'b110) begin
      bad++;
      $display("FAIL cont_drain: hold/req/done=%b, required 110",
               {bus.cpu_hold, bus.mem_req, bus.load_done});
    end
    bus.dn_go = 1'b1;
    step(1);
    for (int i = 4; i < 7; i++) strobe(16'h3000 + 16'(i), 8'h30 + 8'(i), 1'b1, 1'b1);
    bus.dn_go = 1'b0;
    wait_done(300);
    total++;
    if (bus.byte_count !== 17'd7) begin
      bad++;
      $display("FAIL cont_count: byte_count=%0d, required 7", bus.byte_count);
    end
    step(2);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL cont_done: pulses=%0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_session();
    int d0;
    gnt_mode = 1;
    bus.dn_go = 1'b1;
    step(1);
    for (int i = 0; i < 10; i++) strobe(16'h5000 + 16'(i), 8'h80 + 8'(i), 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.mem_req, bus.cpu_hold, bus.load_done, bus.overflow, bus.dn_wait} !== 5'b0) begin
      bad++;
      $display("FAIL midrst_flags: req/hold/done/ovf/wait=%b, required 00000",
               {bus.mem_req, bus.cpu_hold, bus.load_done, bus.overflow, bus.dn_wait});
    end
    total++;
    if ({bus.mem_addr, bus.mem_din, bus.byte_count} !== '0) begin
      bad++;
      $display("FAIL midrst_values: addr=%h din=%h count=%0d, required 0 0 0",
               bus.mem_addr, bus.mem_din, bus.byte_count);
    end
    sb.delete();
    cap_n = 0;
    com_n = 0;
    bus.dn_go = 1'b0;
    d0 = done_cnt;
    step(2);
    reset = 1'b0;
    step(5);
    total++;
    if ((done_cnt != d0) || (bus.cpu_hold !== 1'b0)) begin
      bad++;
      $display("FAIL midrst_quiet: pulses=%0d hold=%b, required 0 0",
               done_cnt - d0, bus.cpu_hold);
    end
    gnt_mode = 0;
    d0 = done_cnt;
    bus.dn_go = 1'b1;
    step(1);
    for (int i = 10; i < 20; i++) strobe(16'h5000 + 16'(i), 8'h80 + 8'(i), 1'b1, 1'b0);
    bus.dn_go = 1'b0;
    wait_done(50);
    total++;
    if (bus.byte_count !== 17'd10) begin
      bad++;
      $display("FAIL midrst_new_count: byte_count=%0d, required 10", bus.byte_count);
    end
    step(2);
    total++;
    if ((done_cnt - d0 != 1) || (sb.size() != 0)) begin
      bad++;
      $display("FAIL midrst_new_done: pulses=%0d pending=%0d, required 1 0",
               done_cnt - d0, sb.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single_session();
    test_back_pressure();
    test_overflow();
    test_held_strobe();
    test_continuation();
    test_reset_mid_session();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
